// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for the RO-PUF: expands a seed into RO-pair selections, races each pair
// and packs the sampled comparator bits into a word. Define PUF_MAJORITY_VOTE_EN for 3-race majority voting.
module puf_challenge_sequencer #(
    parameter int RESP_BITS   = 16,
    parameter int CLR_CYCLES  = 2,
    parameter int WINDOW      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           challenge,
    output logic [3:0]           sel0,
    output logic [3:0]           sel1,
    output logic                 cnt_reset_n,
    input  logic                 response,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] resp_word
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CNT_MAX = (WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [CNT_W-1:0]       phase_cnt;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             lfsr;
    logic [7:0]             lfsr_n;
    logic [7:0]             seed;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   resp_sync;
    logic [1:0]             vote_cnt;
    logic [1:0]             vote_bits;
    logic                   last_vote;
    logic                   last_bit;
    logic                   phase_last;
    logic                   majority;
    logic                   sample_bit;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Never let a ring oscillator race against itself.
    function automatic logic [3:0] pick_sel1(input logic [7:0] l);
        return (l[3:0] == l[7:4]) ? (l[7:4] ^ 4'h1) : l[7:4];
    endfunction

    assign seed       = (challenge == 8'h00) ? 8'hA5 : challenge;
    assign lfsr_n     = lfsr_next(lfsr);
    assign resp_sync  = sync_q[SYNC_STAGES-1];
    assign last_vote  = (vote_cnt == 2'(VOTES - 1));
    assign last_bit   = (idx == IDX_W'(RESP_BITS - 1));
    assign majority   = (vote_bits[0] & vote_bits[1]) |
                        (vote_bits[0] & resp_sync)    |
                        (vote_bits[1] & resp_sync);
    assign sample_bit = (VOTES == 3) ? majority : resp_sync;

    always_comb begin
        phase_last = 1'b0;
        if (state == ST_CLEAR) begin
            phase_last = (phase_cnt == CNT_W'(CLR_CYCLES - 1));
        end else if (state == ST_RUN) begin
            phase_last = (phase_cnt == CNT_W'(WINDOW - 1));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  if (phase_last) state_nxt = ST_RUN;
            ST_RUN:    if (phase_last) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = (last_vote && last_bit) ? ST_DONE : ST_CLEAR;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the counter clear never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            idx         <= '0;
            lfsr        <= 8'h00;
            sync_q      <= '0;
            vote_cnt    <= 2'd0;
            vote_bits   <= 2'b00;
            sel0        <= 4'h0;
            sel1        <= 4'h0;
            cnt_reset_n <= 1'b0;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_word   <= '0;
        end else begin
            state       <= state_nxt;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], response};
            cnt_reset_n <= (state_nxt == ST_RUN);
            phase_cnt   <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;
            resp_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lfsr      <= seed;
                        idx       <= '0;
                        busy      <= 1'b1;
                        resp_word <= '0;
                        vote_cnt  <= 2'd0;
                        sel0      <= seed[3:0];
                        sel1      <= pick_sel1(seed);
                    end
                end
                ST_SAMPLE: begin
                    if (last_vote) begin
                        resp_word[idx] <= sample_bit;
                        lfsr           <= lfsr_n;
                        idx            <= idx + 1'b1;
                        vote_cnt       <= 2'd0;
                        sel0           <= lfsr_n[3:0];
                        sel1           <= pick_sel1(lfsr_n);
                    end else begin
                        vote_bits[vote_cnt[0]] <= resp_sync;
                        vote_cnt               <= vote_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    resp_valid <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer; a small ring-oscillator model drives the response
// from a per-bit pattern and follows the LFSR to predict every pair selection.
module tb_puf_challenge_sequencer;

    localparam int RESP_BITS   = 16;
    localparam int CLR_CYCLES  = 2;
    localparam int WINDOW      = 64;
    localparam int SYNC_STAGES = 2;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif
    localparam int WORD_LAT = 1 + RESP_BITS * VOTES * (CLR_CYCLES + WINDOW + 1);
    localparam int LIMIT    = WORD_LAT + 50;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [7:0]           challenge;
    logic [3:0]           sel0;
    logic [3:0]           sel1;
    logic                 cnt_reset_n;
    logic                 response;
    logic                 busy;
    logic                 resp_valid;
    logic [RESP_BITS-1:0] resp_word;

    int checks = 0;
    int errors = 0;

    int         run_cnt = 0;
    int         race_cnt = 0;
    int         valid_count = 0;
    logic [7:0] model_lfsr = 8'h00;
    logic [7:0] seed_model = 8'h00;
    logic [15:0] pattern = 16'h0000;

    puf_challenge_sequencer #(
        .RESP_BITS(RESP_BITS), .CLR_CYCLES(CLR_CYCLES),
        .WINDOW(WINDOW), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .sel0(sel0), .sel1(sel1), .cnt_reset_n(cnt_reset_n), .response(response),
        .busy(busy), .resp_valid(resp_valid), .resp_word(resp_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] ref_sel1(input logic [7:0] l);
        return (l[3:0] == l[7:4]) ? (l[7:4] ^ 4'h1) : l[7:4];
    endfunction

    // RO model: a race resolves to the pattern bit (or 1,0,1 when voting) after 40 RUN cycles.
    always @(negedge clk) begin
        int bit_i;
        int vote_i;
        logic level;
        if (resp_valid === 1'b1) valid_count++;
        if (busy !== 1'b1) begin
            race_cnt   = 0;
            model_lfsr = seed_model;
        end
        if (cnt_reset_n === 1'b1) begin
            if (run_cnt == 0) begin
                checkOutput("sel0_run", sel0, model_lfsr[3:0]);
                checkOutput("sel1_run", sel1, ref_sel1(model_lfsr));
            end
            run_cnt++;
        end else begin
            if (run_cnt != 0 && reset !== 1'b1) begin
                checkOutput("run_len", run_cnt, WINDOW);
                race_cnt++;
                if (race_cnt % VOTES == 0) model_lfsr = ref_step(model_lfsr);
            end
            run_cnt = 0;
        end
        bit_i  = race_cnt / VOTES;
        vote_i = race_cnt % VOTES;
        level  = (VOTES == 3) ? (vote_i != 1) : pattern[bit_i % 16];
        response = level && (run_cnt >= 40);
    end

    task automatic applyStimulus(input logic [7:0] seed, input logic [15:0] pat);
        logic [7:0] eff;
        eff        = (seed == 8'h00) ? 8'hA5 : seed;
        seed_model = eff;
        pattern    = pat;
        @(negedge clk);
        start     = 1'b1;
        challenge = seed;
        @(negedge clk);
        start     = 1'b0;
        challenge = 8'h11;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("word_cleared", resp_word, 16'h0000);
        checkOutput("sel0_clear", sel0, eff[3:0]);
        checkOutput("sel1_clear", sel1, ref_sel1(eff));
        checkOutput("cnt_clear", cnt_reset_n, 1'b0);
    endtask

    task automatic waitValid(input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
            if (resp_valid === 1'b1) break;
        end
        start = 1'b0;
    endtask

    task automatic runWord(input logic [7:0] seed, input logic [15:0] pat, input int pulse_at);
        int cyc;
        applyStimulus(seed, pat);
        waitValid(pulse_at, cyc);
        checkOutput("latency", cyc, WORD_LAT);
        checkOutput("resp_word", resp_word, (VOTES == 3) ? 16'hFFFF : pat);
        checkOutput("busy_at_valid", busy, 1'b0);
    endtask

    initial begin
        int vc0;
        int guard;
        reset     = 1'b1;
        start     = 1'b1;
        challenge = 8'h3C;
        response  = 1'b0;

        // Reset with start held high
        repeat (3) @(negedge clk);
        checkOutput("rst_sel0", sel0, 4'h0);
        checkOutput("rst_sel1", sel1, 4'h0);
        checkOutput("rst_cnt", cnt_reset_n, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_valid", resp_valid, 1'b0);
        checkOutput("rst_word", resp_word, 16'h0000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("start_in_reset_ignored", busy, 1'b0);

        // Basic word, then back-to-back starts the cycle after resp_valid
        runWord(8'h3C, 16'hFFFF, 0);
        runWord(8'h00, 16'hA5C3, 0);
        runWord(8'h77, 16'h0F31, 0);
        repeat (10) @(negedge clk);
        checkOutput("word_held", resp_word, (VOTES == 3) ? 16'hFFFF : 16'h0F31);

        // Start pulse while busy must not restart the challenge
        vc0 = valid_count;
        runWord(8'h5A, 16'h1234, 300);
        repeat (20) @(negedge clk);
        checkOutput("valid_once", valid_count - vc0, 1);

        // Abort during bit 5
        applyStimulus(8'hC7, 16'hFFFF);
        guard = 0;
        while (!(race_cnt == 5 * VOTES && cnt_reset_n === 1'b1) && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_reached_bit5", guard < LIMIT, 1'b1);
        vc0   = valid_count;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_cnt", cnt_reset_n, 1'b0);
        checkOutput("abort_valid", resp_valid, 1'b0);
        checkOutput("abort_word", resp_word, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (WORD_LAT + 10) @(negedge clk);
        checkOutput("abort_no_valid", valid_count - vc0, 0);
        checkOutput("abort_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
